// File: rtl/streebog_pkg.sv
// Shared widths, IVs, FSM encoding and block padding for the Streebog message controller.
package streebog_pkg;

  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned LEN_WIDTH  = 10;

  localparam logic [DATA_WIDTH-1:0] IV512 = '0;
  localparam logic [DATA_WIDTH-1:0] IV256 = {64{8'h01}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MSG,
    PAD_ISSUE,
    N_ISSUE,
    WAIT_N,
    S_ISSUE,
    WAIT_S
  } state_e;

  // Operand set handed to g_function for one compression call.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] n;
    logic [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] h;
  } g_req_t;

  // Short blocks keep their low 'bits' bits and get a single 1 appended above them.
  function automatic logic [DATA_WIDTH-1:0] pad_block(input logic [DATA_WIDTH-1:0] data,
                                                      input logic [LEN_WIDTH-1:0]  bits);
    logic [DATA_WIDTH-1:0] one_hot;
    one_hot = DATA_WIDTH'(1) << bits;
    if (bits >= LEN_WIDTH'(DATA_WIDTH)) begin
      pad_block = data;
    end else begin
      pad_block = (data & (one_hot - DATA_WIDTH'(1))) | one_hot;
    end
  endfunction

endpackage

// File: rtl/streebog_msg_ctrl_if.sv
// Block-input, g_function and digest signals of the message controller.
interface streebog_msg_ctrl_if;
  import streebog_pkg::*;

  logic                  blk_valid_i;
  logic                  blk_ready_o;
  logic [DATA_WIDTH-1:0] blk_data_i;
  logic                  blk_last_i;
  logic [LEN_WIDTH-1:0]  blk_bits_i;
  logic                  mode256_i;
  logic [DATA_WIDTH-1:0] g_n_o;
  logic [DATA_WIDTH-1:0] g_m_o;
  logic [DATA_WIDTH-1:0] g_h_o;
  logic                  g_valid_o;
  logic [DATA_WIDTH-1:0] g_hash_i;
  logic                  g_hash_valid_i;
  logic [DATA_WIDTH-1:0] hash_o;
  logic                  hash_valid_o;

  // Environment side: block source, g_function and digest sink.
  modport master (
    output blk_valid_i, blk_data_i, blk_last_i, blk_bits_i, mode256_i,
    output g_hash_i, g_hash_valid_i,
    input  blk_ready_o, g_n_o, g_m_o, g_h_o, g_valid_o, hash_o, hash_valid_o
  );

  // Controller side.
  modport slave (
    input  blk_valid_i, blk_data_i, blk_last_i, blk_bits_i, mode256_i,
    input  g_hash_i, g_hash_valid_i,
    output blk_ready_o, g_n_o, g_m_o, g_h_o, g_valid_o, hash_o, hash_valid_o
  );

endinterface

// File: rtl/streebog_add512.sv
// Combinational modular adder for the N and Sigma accumulators.
module streebog_add512
  import streebog_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/streebog_msg_ctrl.sv
// Streebog message-schedule controller: pads blocks, tracks h/N/Sigma and
// sequences every g_function call including the two finalisation calls.
module streebog_msg_ctrl
  import streebog_pkg::*;
(
  input logic               clk_i,
  input logic               rstn_i,
  streebog_msg_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] n_q, n_d;
  logic [DATA_WIDTH-1:0] sigma_q, sigma_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] hash_q, hash_d;
  logic [LEN_WIDTH-1:0]  add_len_q, add_len_d;
  logic                  need_pad_q, need_pad_d;
  logic                  fin_q, fin_d;
  logic                  first_q, first_d;
  logic                  mode_q, mode_d;
  logic                  ready_q, ready_d;
  logic                  g_valid_q, g_valid_d;
  logic                  hash_valid_q, hash_valid_d;
  g_req_t                g_req_q, g_req_d;

  logic [DATA_WIDTH-1:0] n_sum, sigma_sum;
  logic [DATA_WIDTH-1:0] h_cur, blk_m;
  logic                  blk_full;

  streebog_add512 u_add_n (
    .a_i   (n_q),
    .b_i   (DATA_WIDTH'(add_len_q)),
    .sum_o (n_sum)
  );

  streebog_add512 u_add_sigma (
    .a_i   (sigma_q),
    .b_i   (m_q),
    .sum_o (sigma_sum)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    n_d          = n_q;
    sigma_d      = sigma_q;
    m_d          = m_q;
    hash_d       = hash_q;
    add_len_d    = add_len_q;
    need_pad_d   = need_pad_q;
    fin_d        = fin_q;
    first_d      = first_q;
    mode_d       = mode_q;
    g_req_d      = g_req_q;
    g_valid_d    = 1'b0;
    hash_valid_d = 1'b0;
    h_cur        = h_q;
    blk_m        = pad_block(bus.blk_data_i, bus.blk_bits_i);
    blk_full     = (bus.blk_bits_i >= LEN_WIDTH'(DATA_WIDTH));

    unique case (state_q)
      IDLE: begin
        if (bus.blk_valid_i && ready_q) begin
          // A new message restarts from the IV selected by its first block.
          if (first_q) begin
            mode_d  = bus.mode256_i;
            h_cur   = bus.mode256_i ? IV256 : IV512;
            first_d = 1'b0;
          end
          h_d        = h_cur;
          m_d        = blk_m;
          add_len_d  = bus.blk_bits_i;
          need_pad_d = bus.blk_last_i && blk_full;
          fin_d      = bus.blk_last_i;
          g_valid_d  = 1'b1;
          g_req_d    = '{n: n_q, m: blk_m, h: h_cur};
          state_d    = WAIT_MSG;
        end
      end
      WAIT_MSG: begin
        if (bus.g_hash_valid_i) begin
          h_d     = bus.g_hash_i;
          n_d     = n_sum;
          sigma_d = sigma_sum;
          if (!fin_q) begin
            state_d = IDLE;
          end else if (need_pad_q) begin
            state_d = PAD_ISSUE;
          end else begin
            state_d = N_ISSUE;
          end
        end
      end
      PAD_ISSUE: begin
        m_d        = DATA_WIDTH'(1);
        add_len_d  = '0;
        need_pad_d = 1'b0;
        g_valid_d  = 1'b1;
        g_req_d    = '{n: n_q, m: DATA_WIDTH'(1), h: h_q};
        state_d    = WAIT_MSG;
      end
      N_ISSUE: begin
        g_valid_d = 1'b1;
        g_req_d   = '{n: '0, m: n_q, h: h_q};
        state_d   = WAIT_N;
      end
      WAIT_N: begin
        if (bus.g_hash_valid_i) begin
          h_d     = bus.g_hash_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        g_valid_d = 1'b1;
        g_req_d   = '{n: '0, m: sigma_q, h: h_q};
        state_d   = WAIT_S;
      end
      WAIT_S: begin
        if (bus.g_hash_valid_i) begin
          hash_d       = mode_q ? (bus.g_hash_i >> (DATA_WIDTH / 2)) : bus.g_hash_i;
          hash_valid_d = 1'b1;
          n_d          = '0;
          sigma_d      = '0;
          first_d      = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      h_q          <= IV512;
      n_q          <= '0;
      sigma_q      <= '0;
      m_q          <= '0;
      hash_q       <= '0;
      add_len_q    <= '0;
      need_pad_q   <= 1'b0;
      fin_q        <= 1'b0;
      first_q      <= 1'b1;
      mode_q       <= 1'b0;
      ready_q      <= 1'b0;
      g_valid_q    <= 1'b0;
      hash_valid_q <= 1'b0;
      g_req_q      <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      n_q          <= n_d;
      sigma_q      <= sigma_d;
      m_q          <= m_d;
      hash_q       <= hash_d;
      add_len_q    <= add_len_d;
      need_pad_q   <= need_pad_d;
      fin_q        <= fin_d;
      first_q      <= first_d;
      mode_q       <= mode_d;
      ready_q      <= ready_d;
      g_valid_q    <= g_valid_d;
      hash_valid_q <= hash_valid_d;
      g_req_q      <= g_req_d;
    end
  end

  assign bus.blk_ready_o  = ready_q;
  assign bus.g_valid_o    = g_valid_q;
  assign bus.g_n_o        = g_req_q.n;
  assign bus.g_m_o        = g_req_q.m;
  assign bus.g_h_o        = g_req_q.h;
  assign bus.hash_o       = hash_q;
  assign bus.hash_valid_o = hash_valid_q;

endmodule
